// File: rtl/encoder_8x3_serial.sv
// ---------------------------------------------------------------------------
// encoder_8x3_serial
//
// Captures an 8-bit one-hot or multi-hot vector and presents the index of
// each set bit, one per accepted beat, on a valid/ready handshake. The
// LSB_FIRST parameter selects the emission order: 1 emits the lowest set
// index first, 0 emits the highest set index first. After the last beat
// (or immediately for an all-zero vector) the frame closes with a one-cycle
// done pulse. zero accompanies done when the captured vector was empty.
//
// Ports
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   load   in   1  capture request, honoured only while idle
//   in     in   8  vector to encode
//   ready  in   1  consumer accepts out when high together with valid
//   out    out  3  index of the set bit being presented (0 when !valid)
//   valid  out  1  out holds a valid index
//   busy   out  1  frame in progress, load ignored
//   cnt    out  4  population count of the captured vector
//   done   out  1  one-cycle end-of-frame pulse
//   zero   out  1  one-cycle pulse with done when the vector was 0
// ---------------------------------------------------------------------------
module encoder_8x3_serial #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] in,
  input  logic       ready,
  output logic [2:0] out,
  output logic       valid,
  output logic       busy,
  output logic [3:0] cnt,
  output logic       done,
  output logic       zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic [7:0] pend_left;
  logic [2:0] out_nxt;
  logic       valid_nxt;
  logic       busy_nxt;
  logic [3:0] cnt_nxt;
  logic       done_nxt;
  logic       zero_nxt;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // The scan runs towards the preferred end so the last hit wins.
  function automatic logic [2:0] pick_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    pend_left = pend & ~(8'd1 << out);
    out_nxt   = out;
    valid_nxt = valid;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    zero_nxt  = 1'b0;

    case (state)
      IDLE: begin
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
        out_nxt   = 3'd0;
        if (load) begin
          pend_nxt = in;
          cnt_nxt  = popcount8(in);
          busy_nxt = 1'b1;
          if (in != 8'd0) begin
            state_nxt = EMIT;
            valid_nxt = 1'b1;
            out_nxt   = pick_idx(in);
          end else begin
            state_nxt = FIN;
          end
        end
      end

      EMIT: begin
        // Outputs are registered from the post-accept pending set, so the
        // next index appears on the cycle right after acceptance.
        if (ready) begin
          pend_nxt = pend_left;
          if (pend_left != 8'd0) begin
            out_nxt = pick_idx(pend_left);
          end else begin
            state_nxt = FIN;
            valid_nxt = 1'b0;
            out_nxt   = 3'd0;
          end
        end
      end

      FIN: begin
        // FIN spans two cycles: a drain cycle, then the done cycle. The
        // done register itself tells the two apart.
        if (!done) begin
          done_nxt = 1'b1;
          zero_nxt = (cnt == 4'd0);
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
        out_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 8'd0;
      out   <= 3'd0;
      valid <= 1'b0;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      done  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      out   <= out_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      zero  <= zero_nxt;
    end
  end

endmodule

// File: doc/encoder_8x3_serial.md
ENCODER_8X3_SERIAL -- requirements
Module: encoder_8x3_serial

Interface
REQ-001 SHALL have parameter: LSB_FIRST, default 1, emission order (1 = lowest set index first, 0 = highest first).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: load  input  1  capture request for in; honoured only in IDLE.
REQ-005 SHALL have port: in  input  8  one-hot or multi-hot vector to encode.
REQ-006 SHALL have port: ready  input  1  consumer accepts current out when high with valid.
REQ-007 SHALL have port: out  output  3  binary index of the currently presented set bit.
REQ-008 SHALL have port: valid  output  1  out holds a valid index.
REQ-009 SHALL have port: busy  output  1  frame in progress; load ignored.
REQ-010 SHALL have port: cnt  output  4  population count of the captured vector, 0..8.
REQ-011 SHALL have port: done  output  1  one-cycle pulse at end of frame.
REQ-012 SHALL have port: zero  output  1  one-cycle pulse, coincident with done, when captured vector was 0.

Function
REQ-013 SHALL implement states IDLE, EMIT, FIN with registered state, 8-bit pending register pend, and registered outputs.
REQ-014 IDLE: busy=0, valid=0; on load=1 SHALL capture pend<=in and cnt<=popcount(in).
REQ-015 IDLE with load=1 and in!=0 SHALL transition to EMIT; busy=1 and valid=1 SHALL assert on the next cycle (latency 1).
REQ-016 IDLE with load=1 and in==0 SHALL transition to FIN; valid SHALL stay 0.
REQ-017 EMIT: out SHALL equal index of lowest set bit of pend if LSB_FIRST=1, else highest set bit.
REQ-018 EMIT: valid SHALL stay 1 and out SHALL stay stable while ready=0 (no dropped or changed index under backpressure).
REQ-019 EMIT with valid=1 and ready=1 SHALL clear the presented bit of pend; next index presented on the following cycle with no bubble.
REQ-020 EMIT when the accepted bit is the last set bit SHALL transition to FIN; valid=0 on the next cycle.
REQ-021 FIN: done=1 for exactly one cycle, zero=1 in the same cycle if cnt==0, busy=1, then SHALL return to IDLE.
REQ-022 load asserted in EMIT or FIN SHALL be ignored; in SHALL not affect pend outside the IDLE capture cycle.
REQ-023 cnt SHALL hold its captured value until the next accepted load or reset.
REQ-024 Indices emitted per frame SHALL equal cnt, each set bit exactly once, strictly monotonic in the selected order.
REQ-025 Minimum frame length SHALL be cnt+2 cycles from load to done (cnt=0: 2 cycles).
REQ-026 out SHALL read 3'b000 whenever valid=0.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE, pend=0, out=0, valid=0, busy=0, cnt=0, done=0, zero=0, overriding load and ready.
REQ-028 rst asserted mid-frame SHALL abort the frame with no done pulse; remaining bits discarded.
REQ-029 First load SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-030 One-hot sweep: load in=8'b00000001..8'b10000000, ready=1 -> single valid beat each, out=0..7 in turn, cnt=1, done 2 cycles after the beat.
REQ-031 Multi-hot, LSB_FIRST=1: in=8'b10100110, ready=1 -> out sequence 1,2,5,7 on consecutive cycles, cnt=4, done once.
REQ-032 Same vector, LSB_FIRST=0 -> out sequence 7,5,2,1.
REQ-033 Backpressure: in=8'b00011000, ready low 3 cycles then high -> out=3 held with valid=1 for 4 cycles, then out=4, then done.
REQ-034 Zero input: load in=8'h00 -> valid never high, cnt=0, done=1 and zero=1 together 2 cycles after load.
REQ-035 Reset mid-frame: in=8'hFF, rst after 3 accepted beats -> all outputs 0 next cycle, no done; new load in=8'h80 -> out=7, cnt=1.
